// File: rtl/rename_dispatch_ss.sv
// rename_dispatch_ss
//   Rename/dispatch stage between the instruction queue and the ROB / RS.
//   Each cycle it accepts an in-order prefix of up to SS lanes. The prefix is
//   limited by ROB, RS and free-list capacity. The stage resolves intra-bundle
//   RAW hazards (forwarding) and WAW hazards (youngest writer updates the RAT).
//   It allocates physical destinations (x0 takes none) and ROB IDs, and
//   registers the renamed bundle into a valid/ready output stage.
//
// Ports
//   clk, rst (sync, active low), flush
//   iq_*      : per-lane instructions from the queue (lane 0 oldest)
//   iq_pop_cnt: lanes consumed this cycle
//   fl_*      : free-list count / heads in, pop count out
//   rat_*     : RAT read ports (same-cycle data) and per-lane write ports
//   rob_free, rs_free, rob_tail, rob_alloc_cnt : back-end capacity / allocation
//   out_*     : registered renamed bundle, held while out_ready is low
module rename_dispatch_ss #(
  parameter int SS         = 2,
  parameter int PR_ENTRIES = 64,
  parameter int ROB_DEPTH  = 8,
  parameter int PAYLOAD_W  = 96,
  localparam int PRW = $clog2(PR_ENTRIES),
  localparam int RBW = $clog2(ROB_DEPTH),
  localparam int CW  = $clog2(SS+1),
  localparam int FCW = $clog2(PR_ENTRIES+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [SS-1:0]           iq_valid,
  input  logic [SS*5-1:0]         iq_rs1_a,
  input  logic [SS*5-1:0]         iq_rs2_a,
  input  logic [SS*5-1:0]         iq_rd_a,
  input  logic [SS-1:0]           iq_use_rs1,
  input  logic [SS-1:0]           iq_use_rs2,
  input  logic [SS*PAYLOAD_W-1:0] iq_payload,
  output logic [CW-1:0]           iq_pop_cnt,
  input  logic [FCW-1:0]          fl_count,
  input  logic [SS*PRW-1:0]       fl_preg,
  output logic [CW-1:0]           fl_pop_cnt,
  output logic [SS*5-1:0]         rat_rs1_a,
  output logic [SS*5-1:0]         rat_rs2_a,
  input  logic [SS*PRW-1:0]       rat_rs1_p,
  input  logic [SS*PRW-1:0]       rat_rs2_p,
  output logic [SS-1:0]           rat_we,
  output logic [SS*5-1:0]         rat_wa,
  output logic [SS*PRW-1:0]       rat_wd,
  input  logic [CW-1:0]           rob_free,
  input  logic [CW-1:0]           rs_free,
  input  logic [RBW-1:0]          rob_tail,
  output logic [CW-1:0]           rob_alloc_cnt,
  output logic [SS-1:0]           out_valid,
  input  logic                    out_ready,
  output logic [SS*PRW-1:0]       out_rs1_p,
  output logic [SS*PRW-1:0]       out_rs2_p,
  output logic [SS*PRW-1:0]       out_rd_p,
  output logic [SS*5-1:0]         out_rd_a,
  output logic [SS*RBW-1:0]       out_rob_id,
  output logic [SS*PAYLOAD_W-1:0] out_payload
);

  logic [SS-1:0]           r_out_valid;
  logic [SS*PRW-1:0]       r_rs1_p, r_rs2_p, r_rd_p;
  logic [SS*5-1:0]         r_rd_a;
  logic [SS*RBW-1:0]       r_rob_id;
  logic [SS*PAYLOAD_W-1:0] r_payload;

  logic           w_can_load;
  logic [CW-1:0]  w_n;
  logic [CW-1:0]  w_fl_pop;
  logic [SS-1:0]  w_acc;
  logic [SS-1:0]  w_has_rd;
  logic [SS-1:0]  w_we;
  logic [PRW-1:0] w_dst_p  [SS];
  logic [PRW-1:0] w_src1_p [SS];
  logic [PRW-1:0] w_src2_p [SS];

  assign w_can_load = !(|r_out_valid) || out_ready;

  // Accept count: grow the prefix while every limit still holds. All limits
  // are monotone in k, so the first failure ends the prefix.
  always_comb begin : accept
    int  dcnt;
    logic ok;
    w_n  = '0;
    dcnt = 0;
    ok   = 1'b1;
    for (int k = 1; k <= SS; k++) begin
      if (iq_rd_a[(k-1)*5 +: 5] != 5'd0) dcnt++;
      ok = ok && iq_valid[k-1] && (k <= int'(rob_free)) &&
           (k <= int'(rs_free)) && (dcnt <= int'(fl_count));
      if (ok) w_n = CW'(k);
    end
    if (!rst || flush || !w_can_load) w_n = '0;
  end

  always_comb begin : lane_flags
    for (int i = 0; i < SS; i++) begin
      w_has_rd[i] = (iq_rd_a[i*5 +: 5] != 5'd0);
      w_acc[i]    = (i < int'(w_n));
    end
  end

  // Destinations come from the free-list heads in compacted order:
  // x0 writers are skipped and do not consume an entry.
  always_comb begin : dest_alloc
    int m;
    m = 0;
    for (int i = 0; i < SS; i++) begin
      w_dst_p[i] = '0;
      if (w_acc[i] && w_has_rd[i]) begin
        w_dst_p[i] = fl_preg[m*PRW +: PRW];
        m++;
      end
    end
    w_fl_pop = CW'(m);
  end

  // Source rename: start from the RAT and let older accepted writers
  // override it. Ascending scan, so the youngest older writer wins.
  always_comb begin : src_rename
    for (int j = 0; j < SS; j++) begin
      w_src1_p[j] = '0;
      w_src2_p[j] = '0;
      if (iq_use_rs1[j] && iq_rs1_a[j*5 +: 5] != 5'd0) begin
        w_src1_p[j] = rat_rs1_p[j*PRW +: PRW];
        for (int i = 0; i < j; i++)
          if (w_acc[i] && iq_rd_a[i*5 +: 5] == iq_rs1_a[j*5 +: 5])
            w_src1_p[j] = w_dst_p[i];
      end
      if (iq_use_rs2[j] && iq_rs2_a[j*5 +: 5] != 5'd0) begin
        w_src2_p[j] = rat_rs2_p[j*PRW +: PRW];
        for (int i = 0; i < j; i++)
          if (w_acc[i] && iq_rd_a[i*5 +: 5] == iq_rs2_a[j*5 +: 5])
            w_src2_p[j] = w_dst_p[i];
      end
    end
  end

  // WAW: a lane writes the RAT only if no younger accepted lane hits the
  // same arch register.
  always_comb begin : waw
    for (int i = 0; i < SS; i++) begin
      w_we[i] = w_acc[i] && w_has_rd[i];
      for (int k = i + 1; k < SS; k++)
        if (w_acc[k] && iq_rd_a[k*5 +: 5] == iq_rd_a[i*5 +: 5])
          w_we[i] = 1'b0;
    end
  end

  for (genvar g = 0; g < SS; g++) begin : g_pack
    assign rat_wd[g*PRW +: PRW] = w_dst_p[g];
  end

  assign iq_pop_cnt    = w_n;
  assign rob_alloc_cnt = w_n;
  assign fl_pop_cnt    = w_fl_pop;
  assign rat_we        = w_we;
  assign rat_wa        = iq_rd_a;
  assign rat_rs1_a     = iq_rs1_a;
  assign rat_rs2_a     = iq_rs2_a;

  // Output stage. A non-zero w_n already implies rst, !flush and can_load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid <= '0;
      r_rs1_p     <= '0;
      r_rs2_p     <= '0;
      r_rd_p      <= '0;
      r_rd_a      <= '0;
      r_rob_id    <= '0;
      r_payload   <= '0;
    end else if (flush) begin
      r_out_valid <= '0;
    end else if (w_n != '0) begin
      for (int i = 0; i < SS; i++) begin
        r_out_valid[i]             <= w_acc[i];
        r_rs1_p[i*PRW +: PRW]      <= w_src1_p[i];
        r_rs2_p[i*PRW +: PRW]      <= w_src2_p[i];
        r_rd_p[i*PRW +: PRW]       <= w_dst_p[i];
        r_rob_id[i*RBW +: RBW]     <= rob_tail + RBW'(i);
      end
      r_rd_a    <= iq_rd_a;
      r_payload <= iq_payload;
    end else if (out_ready) begin
      r_out_valid <= '0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_rs1_p   = r_rs1_p;
  assign out_rs2_p   = r_rs2_p;
  assign out_rd_p    = r_rd_p;
  assign out_rd_a    = r_rd_a;
  assign out_rob_id  = r_rob_id;
  assign out_payload = r_payload;

endmodule

// File: tb/tb_rename_dispatch_ss.sv
// Bench for rename_dispatch_ss: directed steps followed by random traffic,
// checked against a sequential-rename reference model.
module tb_rename_dispatch_ss;
  localparam int SS  = 2;
  localparam int PW  = 96;
  localparam int PRW = 6;
  localparam int RBW = 3;
  localparam int CW  = 2;
  localparam int FCW = 7;

  logic clk = 1'b0;
  logic rst, flush, out_ready;
  logic [SS-1:0]     iq_valid, iq_use_rs1, iq_use_rs2;
  logic [SS*5-1:0]   iq_rs1_a, iq_rs2_a, iq_rd_a;
  logic [SS*PW-1:0]  iq_payload;
  logic [CW-1:0]     iq_pop_cnt, fl_pop_cnt, rob_alloc_cnt, rob_free, rs_free;
  logic [FCW-1:0]    fl_count;
  logic [SS*PRW-1:0] fl_preg, rat_rs1_p, rat_rs2_p, rat_wd;
  logic [SS*5-1:0]   rat_rs1_a, rat_rs2_a, rat_wa, out_rd_a;
  logic [SS-1:0]     rat_we, out_valid;
  logic [RBW-1:0]    rob_tail;
  logic [SS*PRW-1:0] out_rs1_p, out_rs2_p, out_rd_p;
  logic [SS*RBW-1:0] out_rob_id;
  logic [SS*PW-1:0]  out_payload;

  always #5 clk = ~clk;

  rename_dispatch_ss #(.SS(SS), .PR_ENTRIES(64), .ROB_DEPTH(8), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iq_valid(iq_valid), .iq_rs1_a(iq_rs1_a), .iq_rs2_a(iq_rs2_a), .iq_rd_a(iq_rd_a),
    .iq_use_rs1(iq_use_rs1), .iq_use_rs2(iq_use_rs2), .iq_payload(iq_payload),
    .iq_pop_cnt(iq_pop_cnt), .fl_count(fl_count), .fl_preg(fl_preg), .fl_pop_cnt(fl_pop_cnt),
    .rat_rs1_a(rat_rs1_a), .rat_rs2_a(rat_rs2_a), .rat_rs1_p(rat_rs1_p), .rat_rs2_p(rat_rs2_p),
    .rat_we(rat_we), .rat_wa(rat_wa), .rat_wd(rat_wd),
    .rob_free(rob_free), .rs_free(rs_free), .rob_tail(rob_tail), .rob_alloc_cnt(rob_alloc_cnt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_p(out_rs1_p), .out_rs2_p(out_rs2_p), .out_rd_p(out_rd_p), .out_rd_a(out_rd_a),
    .out_rob_id(out_rob_id), .out_payload(out_payload)
  );

  // per-lane stimulus
  bit             t_v  [SS];
  bit             t_u1 [SS];
  bit             t_u2 [SS];
  logic [4:0]     t_rd [SS];
  logic [4:0]     t_rs1[SS];
  logic [4:0]     t_rs2[SS];
  logic [PRW-1:0] t_p1 [SS];
  logic [PRW-1:0] t_p2 [SS];
  logic [PRW-1:0] t_flp[SS];
  logic [PW-1:0]  t_pl [SS];

  for (genvar g = 0; g < SS; g++) begin : g_drv
    assign iq_valid[g]              = t_v[g];
    assign iq_use_rs1[g]            = t_u1[g];
    assign iq_use_rs2[g]            = t_u2[g];
    assign iq_rd_a[g*5 +: 5]        = t_rd[g];
    assign iq_rs1_a[g*5 +: 5]       = t_rs1[g];
    assign iq_rs2_a[g*5 +: 5]       = t_rs2[g];
    assign rat_rs1_p[g*PRW +: PRW]  = t_p1[g];
    assign rat_rs2_p[g*PRW +: PRW]  = t_p2[g];
    assign fl_preg[g*PRW +: PRW]    = t_flp[g];
    assign iq_payload[g*PW +: PW]   = t_pl[g];
  end

  // reference model state
  int             m_n, m_flpop;
  bit             m_we [SS];
  logic [PRW-1:0] m_rs1[SS], m_rs2[SS], m_rd[SS];
  bit             e_v  [SS];
  logic [PRW-1:0] e_rs1[SS], e_rs2[SS], e_rd[SS];
  logic [4:0]     e_rda[SS];
  logic [RBW-1:0] e_rob[SS];
  logic [PW-1:0]  e_pl [SS];
  bit             was_rst;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rename the bundle one instruction at a time against a scratch map of
  // the bundle's own writes, as a sequential machine would.
  task automatic model_comb();
    logic [PRW-1:0] map [32];
    bit             has [32];
    int             last[32];
    int             alloc, d;
    bit             any, stop;
    any = 0;
    for (int i = 0; i < SS; i++) any |= e_v[i];
    m_n = 0;
    if (rst && !flush && (!any || out_ready)) begin
      d = 0; stop = 0;
      for (int k = 1; k <= SS; k++) begin
        if (!stop) begin
          if (!t_v[k-1]) stop = 1;
          else begin
            if (t_rd[k-1] != 0) d++;
            if (k > int'(rob_free) || k > int'(rs_free) || d > int'(fl_count)) stop = 1;
            else m_n = k;
          end
        end
      end
    end
    for (int a = 0; a < 32; a++) begin map[a] = '0; has[a] = 0; last[a] = -1; end
    alloc = 0;
    for (int j = 0; j < SS; j++) begin
      if (!t_u1[j] || t_rs1[j] == 0) m_rs1[j] = '0;
      else if (has[t_rs1[j]])        m_rs1[j] = map[t_rs1[j]];
      else                           m_rs1[j] = t_p1[j];
      if (!t_u2[j] || t_rs2[j] == 0) m_rs2[j] = '0;
      else if (has[t_rs2[j]])        m_rs2[j] = map[t_rs2[j]];
      else                           m_rs2[j] = t_p2[j];
      m_rd[j] = '0;
      if (j < m_n && t_rd[j] != 0) begin
        m_rd[j] = t_flp[alloc];
        alloc++;
        map[t_rd[j]] = m_rd[j];
        has[t_rd[j]] = 1;
        last[t_rd[j]] = j;
      end
    end
    m_flpop = alloc;
    for (int i = 0; i < SS; i++)
      m_we[i] = (i < m_n) && t_rd[i] != 0 && last[t_rd[i]] == i;
  endtask

  task automatic model_edge();
    was_rst = !rst;
    if (!rst) begin
      for (int i = 0; i < SS; i++) begin
        e_v[i] = 0; e_rs1[i] = '0; e_rs2[i] = '0; e_rd[i] = '0;
        e_rda[i] = '0; e_rob[i] = '0; e_pl[i] = '0;
      end
    end else if (flush) begin
      for (int i = 0; i < SS; i++) e_v[i] = 0;
    end else if (m_n > 0) begin
      for (int i = 0; i < SS; i++) begin
        e_v[i] = (i < m_n);
        e_rs1[i] = m_rs1[i]; e_rs2[i] = m_rs2[i]; e_rd[i] = m_rd[i];
        e_rda[i] = t_rd[i]; e_pl[i] = t_pl[i];
        e_rob[i] = RBW'((int'(rob_tail) + i) % 8);
      end
    end else if (out_ready) begin
      for (int i = 0; i < SS; i++) e_v[i] = 0;
    end
  endtask

  // One cycle: check combinational outputs at the falling edge, then
  // registered outputs just after the rising edge.
  task automatic cyc();
    logic [SS-1:0] wp, vp;
    @(negedge clk);
    model_comb();
    chk("iq_pop_cnt", iq_pop_cnt, m_n);
    chk("rob_alloc_cnt", rob_alloc_cnt, m_n);
    chk("fl_pop_cnt", fl_pop_cnt, m_flpop);
    for (int i = 0; i < SS; i++) wp[i] = m_we[i];
    chk("rat_we", rat_we, wp);
    for (int i = 0; i < SS; i++)
      if (m_we[i]) begin
        chk("rat_wa", rat_wa[i*5 +: 5], t_rd[i]);
        chk("rat_wd", rat_wd[i*PRW +: PRW], m_rd[i]);
      end
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < SS; i++) vp[i] = e_v[i];
    chk("out_valid", out_valid, vp);
    for (int i = 0; i < SS; i++)
      if (e_v[i] || was_rst) begin
        chk("out_rs1_p", out_rs1_p[i*PRW +: PRW], e_rs1[i]);
        chk("out_rs2_p", out_rs2_p[i*PRW +: PRW], e_rs2[i]);
        chk("out_rd_p", out_rd_p[i*PRW +: PRW], e_rd[i]);
        chk("out_rd_a", out_rd_a[i*5 +: 5], e_rda[i]);
        chk("out_rob_id", out_rob_id[i*RBW +: RBW], e_rob[i]);
        chk("out_payload", out_payload[i*PW +: PW], e_pl[i]);
      end
  endtask

  task automatic set_lane(input int i, input bit v, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [PRW-1:0] p1, input logic [PRW-1:0] p2);
    t_v[i] = v; t_rd[i] = rd; t_rs1[i] = rs1; t_rs2[i] = rs2;
    t_u1[i] = 1; t_u2[i] = 1; t_p1[i] = p1; t_p2[i] = p2;
    t_pl[i] = {$urandom, $urandom, $urandom};
  endtask

  task automatic set_env(input int rf, input int sf, input int fc, input int tail,
                         input logic [PRW-1:0] f0, input logic [PRW-1:0] f1);
    rob_free = CW'(rf); rs_free = CW'(sf); fl_count = FCW'(fc);
    rob_tail = RBW'(tail); t_flp[0] = f0; t_flp[1] = f1;
  endtask

  initial begin
    rst = 0; flush = 0; out_ready = 1;
    for (int i = 0; i < SS; i++) e_v[i] = 0;
    set_env(2, 2, 10, 0, 1, 2);
    set_lane(0, 1, 1, 2, 3, 5, 6);
    set_lane(1, 1, 4, 1, 5, 7, 8);
    cyc(); cyc();
    rst = 1;

    // full bundle with RAW forwarding
    set_env(2, 2, 10, 6, 40, 41);
    set_lane(0, 1, 1, 2, 3, 7, 8);
    set_lane(1, 1, 4, 1, 5, 33, 9);
    cyc();
    chk("bundle_rs1_l0", out_rs1_p[0 +: PRW], 7);
    chk("bundle_rs1_l1", out_rs1_p[PRW +: PRW], 40);
    chk("bundle_rd_l1", out_rd_p[PRW +: PRW], 41);
    chk("bundle_rob_l1", out_rob_id[RBW +: RBW], 7);

    // ROB wrap
    set_env(2, 2, 10, 7, 42, 43);
    cyc();
    chk("wrap_rob_l0", out_rob_id[0 +: RBW], 7);
    chk("wrap_rob_l1", out_rob_id[RBW +: RBW], 0);

    // WAW, then x0 destination
    set_lane(0, 1, 3, 2, 0, 11, 12);
    set_lane(1, 1, 3, 3, 4, 13, 14);
    set_env(2, 2, 10, 1, 20, 21);
    cyc();
    set_lane(0, 1, 0, 2, 3, 11, 12);
    set_lane(1, 1, 6, 7, 8, 13, 14);
    set_env(2, 2, 10, 2, 22, 23);
    cyc();
    chk("x0_rd_l0", out_rd_p[0 +: PRW], 0);
    chk("x0_rd_l1", out_rd_p[PRW +: PRW], 22);

    // capacity limits
    set_lane(0, 1, 1, 2, 3, 1, 2);
    set_lane(1, 1, 4, 5, 6, 3, 4);
    set_env(2, 1, 10, 3, 24, 25);
    cyc();
    chk("rsfree_valid", out_valid, 2'b01);
    set_lane(0, 1, 0, 2, 3, 1, 2);
    set_env(2, 2, 0, 4, 26, 27);
    cyc();
    chk("flcount_valid", out_valid, 2'b01);
    set_lane(0, 0, 1, 2, 3, 1, 2);
    set_env(2, 2, 10, 5, 28, 29);
    cyc();
    chk("hole_valid", out_valid, 2'b00);

    // backpressure
    set_lane(0, 1, 7, 1, 2, 3, 4);
    set_lane(1, 1, 8, 7, 9, 5, 6);
    set_env(2, 2, 10, 0, 30, 31);
    cyc();
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      set_lane(0, 1, 9, 1, 2, 10 + c, 4);
      set_env(2, 2, 10, c, 32, 33);
      cyc();
    end
    out_ready = 1;
    cyc();

    // flush while full
    flush = 1;
    set_env(2, 2, 10, 3, 34, 35);
    cyc();
    flush = 0;

    // reset in the middle of a stall
    cyc();
    out_ready = 0;
    cyc();
    rst = 0;
    cyc();
    rst = 1; out_ready = 1;

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < SS; i++) begin
        set_lane(i, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 PRW'($urandom), PRW'($urandom));
        t_u1[i] = $urandom_range(0, 3) != 0;
        t_u2[i] = $urandom_range(0, 3) != 0;
      end
      set_env($urandom_range(0, SS), $urandom_range(0, SS), $urandom_range(0, 3),
              $urandom_range(0, 7), PRW'($urandom), PRW'($urandom));
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      rst = $urandom_range(0, 31) != 0;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rename_dispatch_ss.md
Name: rename_dispatch_ss

Overview:
Parametrised rename/dispatch stage between the instruction queue and the ROB / reservation station. Each cycle it accepts an in-order prefix of up to SS instructions, limited by ROB, RS and free-list capacity. It resolves intra-bundle RAW and WAW hazards, allocates physical destinations (x0 consumes none) and ROB IDs, and presents results through a registered valid/ready output stage with stall hold and flush.

Parameters:
SS, 2, superscalar width (lanes), >=1
PR_ENTRIES, 64, physical registers; PRW = $clog2(PR_ENTRIES)
ROB_DEPTH, 8, ROB entries, power of two; RBW = $clog2(ROB_DEPTH)
PAYLOAD_W, 96, opaque per-lane decode payload passed through (pc, inst, ctrl)
CW, derived $clog2(SS+1), count width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
flush  in  1  squash output register and block acceptance this cycle
iq_valid  in  SS  per-lane valid from inst queue (lane 0 oldest)
iq_rs1_a, iq_rs2_a, iq_rd_a  in  SS x 5  arch sources / dest
iq_use_rs1, iq_use_rs2  in  SS  lane reads rs1 / rs2
iq_payload  in  SS x PAYLOAD_W  passthrough
iq_pop_cnt  out  CW  lanes consumed this cycle
fl_count  in  $clog2(PR_ENTRIES+1)  free physical regs available
fl_preg  in  SS x PRW  next SS free-list heads, in order
fl_pop_cnt  out  CW  free-list entries consumed
rat_rs1_a, rat_rs2_a  out  SS x 5  RAT read addresses (= iq_rs*_a)
rat_rs1_p, rat_rs2_p  in  SS x PRW  RAT read data, same cycle
rat_we  out  SS  RAT write enable per lane
rat_wa  out  SS x 5  RAT write arch reg
rat_wd  out  SS x PRW  RAT write phys reg
rob_free, rs_free  in  CW  free slots (saturated at SS)
rob_tail  in  RBW  ROB ID for lane 0 of this bundle
rob_alloc_cnt  out  CW  ROB entries allocated
out_valid  out  SS  registered per-lane valid
out_ready  in  1  consumer takes the whole registered bundle
out_rs1_p, out_rs2_p, out_rd_p  out  SS x PRW  renamed regs
out_rd_a  out  SS x 5  arch dest
out_rob_id  out  SS x RBW  allocated ROB ID
out_payload  out  SS x PAYLOAD_W  passthrough

Behaviour:
- Reset (rst==0 at posedge): out_valid=0; other out_* regs =0. Combinational count outputs and rat_we are forced 0 while rst==0.
- can_load = !out_valid_any | out_ready; block is idle when flush.
- n = largest k<=SS such that:
  - lanes 0..k-1 all valid (prefix only; a hole stops acceptance);
  - k<=rob_free and k<=rs_free;
  - count(lanes<k with rd_a!=0) <= fl_count;
  - can_load && !flush.
  Otherwise n=0.
- iq_pop_cnt = rob_alloc_cnt = n; fl_pop_cnt = number of accepted lanes with rd_a!=0.
- Dest alloc: accepted lane i with rd_a!=0 gets fl_preg[m], m = count of lanes j<i with rd_a!=0 (compacted). rd_a==0 gets out_rd_p=0, no RAT write.
- ROB ID: lane i gets (rob_tail + i) mod ROB_DEPTH (natural RBW-bit wrap).
- Source rename, lane j, src s: if some accepted i<j has rd_a==s!=0, take the youngest such lane's new preg; else take rat_*_p[j]. Unused source (use_rs*=0) and s==0 give preg 0.
- RAT write: rat_we[i]=1 iff lane i accepted, rd_a!=0, and no accepted younger lane in the bundle writes the same rd_a (WAW: youngest wins). rat_wa/rat_wd are valid when the matching rat_we is set.
- Output register: when n>0 && can_load, lanes <n load with out_valid=1 and lanes >=n get out_valid=0. When out_ready && n==0, out_valid clears. When out_valid_any && !out_ready, all out_* hold. Latency: 1 cycle from accept to out_valid.
- flush: out_valid<=0 next edge and n=0 in the same cycle. Flush has priority over out_ready and load.
- Mid-operation reset behaves like flush plus clearing all regs. No partial state survives.

Test Plan:
- Full bundle SS=2: x1<-x2+x3, x4<-x1+x5; RAT x2=7,x3=8,x5=9; fl_preg={40,41}; rob_tail=6 -> next cycle out_rs1_p={7,40}, out_rd_p={40,41}, out_rob_id={6,7}; fl_pop_cnt=2; rat_we=2'b11.
- ROB wrap: rob_tail=7, SS=2 -> out_rob_id={7,0}.
- WAW plus x0: lanes write x3,x3 -> rat_we=2'b10. Lanes write x0,x6 -> fl_pop_cnt=1, lane1 gets fl_preg[0], out_rd_p[0]=0.
- Capacity limits: 2 valid lanes with rs_free=1 -> iq_pop_cnt=1, out_valid=2'b01. fl_count=0 with lane0 rd=x0, lane1 rd=x4 -> n=1. iq_valid=2'b10 -> n=0.
- Backpressure: out_ready=0 for 3 cycles with new input present -> n=0 and outputs stable. out_ready=1 -> new bundle loads the same cycle the old one is taken.
- Flush while out_valid=2'b11 and iq valid -> n=0 that cycle, out_valid=0 next. rst low mid-stall -> all outputs 0 next edge.
